// File: rtl/psum_collector.sv
// psum_collector: per-row psum buffer that collects array writes, then drains them row-major after done rises
module psum_collector #(
   parameter int ARRAY_ROWS = 3,
   parameter int PSUM_DEPTH = 3,
   parameter int DATA_W = 32,
   localparam int RW = ARRAY_ROWS > 1 ? $clog2(ARRAY_ROWS) : 1,
   localparam int CW = PSUM_DEPTH > 1 ? $clog2(PSUM_DEPTH) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [0:ARRAY_ROWS-1]               psum_valid,
   input  logic [0:ARRAY_ROWS-1][31:0]         psum_addr,
   input  logic [0:ARRAY_ROWS-1][DATA_W-1:0]   psum_data,
   input  logic                                done,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DATA_W-1:0]                   out_data,
   output logic [RW-1:0]                       out_row,
   output logic [CW-1:0]                       out_col,
   output logic                                out_last,
   output logic                                busy,
   output logic                                err
);
   typedef enum logic {COLLECT, DRAIN} state_t;
   state_t state, state_nxt;
   logic done_q;
   logic [RW-1:0] rd_row;
   logic [CW-1:0] rd_col;
   logic [ARRAY_ROWS-1:0][PSUM_DEPTH-1:0][DATA_W-1:0] mem;
   logic col_end, at_end, fire;
   assign col_end = rd_col == CW'(PSUM_DEPTH - 1);
   assign at_end  = col_end && rd_row == RW'(ARRAY_ROWS - 1);
   assign fire    = state == DRAIN && out_ready;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= COLLECT;
      else state <= state_nxt;
   // next state and drain outputs; everything reads zero while collecting
   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      out_row   = '0;
      out_col   = '0;
      if (state == COLLECT) begin
         if (done && !done_q) state_nxt = DRAIN;
      end else begin
         out_valid = 1'b1;
         busy      = 1'b1;
         out_last  = at_end;
         out_data  = mem[rd_row][rd_col];
         out_row   = rd_row;
         out_col   = rd_col;
         if (out_ready && at_end) state_nxt = COLLECT;
      end
   end
   // buffer writes, error capture, drain pointer and clear-after-drain
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem    <= '0;
         done_q <= 1'b0;
         err    <= 1'b0;
         rd_row <= '0;
         rd_col <= '0;
      end else begin
         done_q <= done;
         for (int r = 0; r < ARRAY_ROWS; r++)
            if (psum_valid[r]) begin
               if (state == COLLECT && psum_addr[r] < 32'(PSUM_DEPTH)) mem[r][psum_addr[r][CW-1:0]] <= psum_data[r];
               else err <= 1'b1;
            end
         if (fire) begin
            rd_col <= col_end ? '0 : rd_col + 1'b1;
            rd_row <= at_end ? '0 : col_end ? rd_row + 1'b1 : rd_row;
            if (at_end) mem <= '0;
         end
      end
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: table-driven fills with a scoreboard of expected drain beats
module tb_psum_collector;
   localparam int R = 3, D = 3, W = 32;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [0:R-1] psum_valid = '0;
   logic [0:R-1][31:0] psum_addr = '0;
   logic [0:R-1][W-1:0] psum_data = '0;
   logic done = 1'b0, out_ready = 1'b0;
   logic out_valid, out_last, busy, err;
   logic [W-1:0] out_data;
   logic [1:0] out_row, out_col;
   typedef struct { logic [0:R-1] v; logic [0:R-1][31:0] a; logic [0:R-1][W-1:0] d; } wr_t;
   typedef struct { int r; logic [31:0] a; logic [W-1:0] d; logic e; } ev_t;
   typedef struct { logic [1:0] r; logic [1:0] c; logic l; logic [W-1:0] d; } beat_t;
   beat_t q[$];
   logic [W-1:0] mdl [R][D];
   logic exp_err = 1'b0;
   int n_chk = 0, n_fail = 0;
   wr_t fill_tbl[5];
   ev_t err_tbl[6];
   wr_t none;

   always #5 clk = ~clk;

   psum_collector #(.ARRAY_ROWS(R), .PSUM_DEPTH(D), .DATA_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .psum_valid(psum_valid), .psum_addr(psum_addr), .psum_data(psum_data),
      .done(done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
      .out_col(out_col), .out_last(out_last), .busy(busy), .err(err));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic wr_t mk1(input int r, input logic [31:0] a, input logic [W-1:0] d);
      wr_t w;
      w.v = '0; w.a = '0; w.d = '0;
      w.v[r] = 1'b1; w.a[r] = a; w.d[r] = d;
      return w;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < R; r++) for (int c = 0; c < D; c++) mdl[r][c] = '0;
      q.delete();
      exp_err = 1'b0;
   endtask

   // one collect-phase cycle: inputs held across exactly one rising edge
   task automatic drive(input wr_t w, input logic dn);
      @(posedge clk); #1;
      psum_valid = w.v; psum_addr = w.a; psum_data = w.d; done = dn;
      for (int r = 0; r < R; r++)
         if (w.v[r]) begin
            if (w.a[r] < D) mdl[r][w.a[r]] = w.d[r];
            else exp_err = 1'b1;
         end
      @(posedge clk); #1;
      psum_valid = '0;
   endtask

   task automatic start(input wr_t w, input bit hold);
      drive(w, 1'b1);
      for (int r = 0; r < R; r++)
         for (int c = 0; c < D; c++) begin
            q.push_back('{r: 2'(r), c: 2'(c), l: (r == R-1 && c == D-1), d: mdl[r][c]});
            mdl[r][c] = '0;
         end
      if (!hold) done = 1'b0;
   endtask

   task automatic drain(input int mode, input int nb, input bit wr_bad);
      int popped = 0;
      beat_t e;
      for (int cyc = 0; cyc < 200 && popped < nb && q.size() > 0; cyc++) begin
         @(posedge clk); #1;
         out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
         psum_valid = (wr_bad && cyc == 1) ? '1 : '0;
         psum_addr = '0;
         psum_data = {R{32'hDEAD}};
         if (wr_bad && cyc == 1) exp_err = 1'b1;
         @(negedge clk);
         chk("out_valid", out_valid, 1);
         e = q[0];
         chk(out_ready ? "beat" : "stall", {out_row, out_col, out_last, out_data}, {e.r, e.c, e.l, e.d});
         if (out_ready) begin
            void'(q.pop_front());
            popped++;
         end
      end
      psum_valid = '0;
      if (popped < nb && q.size() > 0) chk("drain_timeout", 64'(q.size()), 0);
   endtask

   task automatic finish_drain();
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("valid_after", out_valid, 0);
      chk("err", err, exp_err);
   endtask

   task automatic chk_idle(input string nm);
      chk(nm, {out_valid, out_last, busy, out_row, out_col, out_data}, 0);
      chk({nm, "_err"}, err, 0);
   endtask

   task automatic fill(input int base);
      wr_t w;
      for (int k = 0; k < 5; k++) begin
         w = fill_tbl[k];
         for (int r = 0; r < R; r++) w.d[r] = w.d[r] + W'(base);
         drive(w, 1'b0);
      end
   endtask

   initial begin
      none.v = '0; none.a = '0; none.d = '0;
      for (int k = 0; k < 5; k++) begin
         fill_tbl[k] = none;
         for (int r = 0; r < R; r++)
            if (k - r >= 0 && k - r < D) begin
               fill_tbl[k].v[r] = 1'b1;
               fill_tbl[k].a[r] = 32'(k - r);
               fill_tbl[k].d[r] = W'(10 * r + k - r);
            end
      end
      err_tbl = '{'{0, 0, 32'h11, 0}, '{1, 2, 32'h22, 0}, '{2, 1, 32'h33, 0},
                  '{1, 3, 32'h55, 1}, '{0, 100, 32'h66, 1}, '{2, 0, 32'h77, 1}};
      model_reset();
      #22;
      chk_idle("reset");
      rst_n = 1'b1;
      // basic fill and free-flowing drain
      fill(0);
      start(none, 0);
      drain(0, 9, 0);
      finish_drain();
      // same fill under backpressure
      fill(0);
      start(none, 0);
      drain(1, 9, 0);
      finish_drain();
      // out-of-range writes set err; writes during drain are dropped
      for (int i = 0; i < 6; i++) begin
         drive(mk1(err_tbl[i].r, err_tbl[i].a, err_tbl[i].d), 1'b0);
         @(negedge clk);
         chk("err_tbl", err, err_tbl[i].e);
      end
      start(none, 0);
      drain(0, 9, 1);
      finish_drain();
      // partial fill, write in the done-rise cycle, done held high
      drive(mk1(0, 1, 32'h5), 1'b0);
      drive(mk1(1, 0, 32'h9), 1'b0);
      start(mk1(2, 2, 32'hAB), 1);
      drain(0, 9, 0);
      finish_drain();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("no_retrigger", busy, 0);
      end
      done = 1'b0;
      // reset in the middle of a drain
      fill(100);
      start(none, 0);
      drain(0, 4, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      out_ready = 1'b0;
      #1;
      chk_idle("mid_reset");
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(mk1(0, 0, 32'h200), 1'b0);
      drive(mk1(2, 1, 32'h221), 1'b0);
      start(none, 0);
      drain(0, 9, 0);
      finish_drain();
      // back-to-back runs leave no stale data
      fill(300);
      start(none, 0);
      drain(1, 9, 0);
      finish_drain();
      drive(mk1(1, 1, 32'h7), 1'b0);
      start(none, 0);
      drain(0, 9, 0);
      finish_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter ARRAY_ROWS, default 3, number of PE-array rows (psum lanes).
REQ-002 SHALL have parameter PSUM_DEPTH, default 3, number of psum entries stored per row.
REQ-003 SHALL have parameter DATA_W, default 32, psum data width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port psum_valid  input  [0:ARRAY_ROWS-1]  per-row psum write strobe from the controller.
REQ-008 SHALL have port psum_addr  input  [0:ARRAY_ROWS-1][31:0]  per-row entry index for the write.
REQ-009 SHALL have port psum_data  input  [0:ARRAY_ROWS-1][DATA_W-1:0]  per-row psum value from the array.
REQ-010 SHALL have port done  input  1  controller done level; its rising edge starts draining.
REQ-011 SHALL have port out_valid  output  1  drain data valid.
REQ-012 SHALL have port out_ready  input  1  downstream ready.
REQ-013 SHALL have port out_data  output  DATA_W  drained psum.
REQ-014 SHALL have port out_row  output  $clog2(ARRAY_ROWS) (min 1)  row index of out_data.
REQ-015 SHALL have port out_col  output  $clog2(PSUM_DEPTH) (min 1)  entry index of out_data.
REQ-016 SHALL have port out_last  output  1  final drain beat.
REQ-017 SHALL have port busy  output  1  high in DRAIN.
REQ-018 SHALL have port err  output  1  sticky error flag.

Function
REQ-019 SHALL implement two states: COLLECT (accept writes) and DRAIN (stream buffer out).
REQ-020 In COLLECT, for each row r with psum_valid[r]=1 and psum_addr[r] < PSUM_DEPTH, SHALL write psum_data[r] to buf[r][psum_addr[r]]; written value visible from the next cycle.
REQ-021 Rows SHALL write independently in the same cycle; repeated writes to one entry SHALL keep the last value.
REQ-022 A write with psum_addr[r] >= PSUM_DEPTH SHALL be dropped and SHALL set err.
REQ-023 Any psum_valid bit high in DRAIN SHALL be dropped and SHALL set err.
REQ-024 err SHALL stay high until reset.
REQ-025 SHALL register done into done_q; done=1 && done_q=0 in COLLECT SHALL move the state to DRAIN the next cycle; done held high SHALL NOT retrigger.
REQ-026 A write and a done rising edge in the same cycle SHALL both take effect; the write appears in the drain.
REQ-027 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal buf[rd_row][rd_col] (combinational read), out_row=rd_row, out_col=rd_col.
REQ-028 rd_row/rd_col SHALL start at 0,0 on DRAIN entry and advance only on out_valid && out_ready, row-major: col increments, wraps to 0 at PSUM_DEPTH-1 with row+1.
REQ-029 With out_ready=0, out_data/out_row/out_col SHALL hold stable.
REQ-030 out_last SHALL be 1 only when rd_row=ARRAY_ROWS-1 and rd_col=PSUM_DEPTH-1 in DRAIN.
REQ-031 Handshake on the out_last beat SHALL clear all buf entries to 0, reset rd_row/rd_col to 0, and return to COLLECT next cycle; exactly ARRAY_ROWS*PSUM_DEPTH beats per drain.
REQ-032 Entries never written since last clear SHALL drain as 0.
REQ-033 In COLLECT, out_valid, out_last, busy SHALL be 0; out_data, out_row, out_col SHALL be 0.
REQ-034 A done rising edge during DRAIN SHALL be ignored.

Reset
REQ-035 rst_n low SHALL immediately force state COLLECT, all buf entries 0, rd_row/rd_col 0, done_q 0, err 0, all outputs 0, including mid-drain.

Verification
REQ-036 Fill: 3x3, write buf[r][c]=10*r+c over skewed cycles, pulse done, out_ready=1 -> 9 beats 0,1,2,10,11,12,20,21,22; out_last on beat 9 only; busy drops after.
REQ-037 Backpressure: same fill, out_ready toggled 1,0,0,1,... -> no beat lost or duplicated, data stable while stalled, order unchanged.
REQ-038 Errors: write row1 psum_addr=3 -> dropped, err=1; write during DRAIN -> dropped, drained values unchanged, err stays 1.
REQ-039 Edge cases: write buf[2][2]=0xAB in done-rise cycle -> last beat 0xAB; done held high 20 cycles -> single drain; partial fill -> unwritten entries drain 0.
REQ-040 Reset: assert rst_n=0 after 4 drain beats -> outputs 0 at once; after release, new fill+done drains only new values, starting at row 0, col 0.
REQ-041 Back-to-back: second fill after drain -> no stale values from first run.
